pfd_tdc_counter: RTL and testbench

//  Counter-based phase/frequency detector feeding the ADPLL digital loop filter.
//  - Measures the time between the reference edge and the DCO-divided feedback edge, in cycles of the fast sampling clock clk.
//  - Outputs an unsigned magnitude on slave_out plus a lead flag: lead=1 means feedback leads, lead=0 means reference leads.
//  - slave_out/lead connect directly to the loop filter inputs master_in/lead.

---
 rtl/pfd_tdc_counter.sv | 157 +++++++++++++++
 tb/tb_pfd_tdc_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pfd_tdc_counter.sv
// Counter-based phase/frequency detector: measures the clk-cycle distance between
// synchronized rising edges of ref_in and fb_in and reports magnitude plus lead flag.
module pfd_tdc_counter #(
  parameter int MAG_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ref_in,
  input  logic                 fb_in,
  output logic [MAG_WIDTH-1:0] slave_out,
  output logic                 lead,
  output logic                 slave_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [MAG_WIDTH-1:0] MAG_MAX     = '1;
  localparam logic [CNT_W-1:0]     CNT_SAT     = CNT_W'(MAG_MAX);
  localparam logic [CNT_W-1:0]     CNT_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_FB  = 2'd1;
  localparam logic [1:0] WAIT_REF = 2'd2;

  logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
  logic [SYNC_STAGES-1:0] fb_sync_q, fb_sync_d;
  logic                   ref_prev_q, ref_prev_d;
  logic                   fb_prev_q, fb_prev_d;
  logic                   ref_e_q, ref_e_d;
  logic                   fb_e_q, fb_e_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MAG_WIDTH-1:0]   slave_out_q, slave_out_d;
  logic                   lead_q, lead_d;
  logic                   slave_valid_q, slave_valid_d;

  function automatic logic [MAG_WIDTH-1:0] sat_mag(input logic [CNT_W-1:0] c);
    if (c > CNT_SAT) return MAG_MAX;
    return c[MAG_WIDTH-1:0];
  endfunction

  // Synchronizers followed by a registered rising-edge detector
  always_comb begin
    ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], ref_in};
    fb_sync_d  = {fb_sync_q[SYNC_STAGES-2:0], fb_in};
    ref_prev_d = ref_sync_q[SYNC_STAGES-1];
    fb_prev_d  = fb_sync_q[SYNC_STAGES-1];
    ref_e_d    = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
    fb_e_d     = fb_sync_q[SYNC_STAGES-1] & ~fb_prev_q;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slave_out_d   = slave_out_q;
    lead_d        = lead_q;
    slave_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_e_q && fb_e_q) begin
          slave_valid_d = 1'b1;
          slave_out_d   = '0;
        end else if (ref_e_q) begin
          state_d = WAIT_FB;
          cnt_d   = CNT_ONE;
        end else if (fb_e_q) begin
          state_d = WAIT_REF;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_FB: begin
        // Closing edge wins over a simultaneous repeat of the opening edge
        if (fb_e_q) begin
          slave_valid_d = 1'b1;
          slave_out_d   = sat_mag(cnt_q);
          lead_d        = 1'b0;
          state_d       = IDLE;
          cnt_d         = '0;
        end else if (ref_e_q) begin
          slave_valid_d = 1'b1;
          slave_out_d   = MAG_MAX;
          lead_d        = 1'b0;
          cnt_d         = CNT_ONE;
        end else if (cnt_q == CNT_TIMEOUT) begin
          slave_valid_d = 1'b1;
          slave_out_d   = MAG_MAX;
          lead_d        = 1'b0;
          state_d       = IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_REF: begin
        if (ref_e_q) begin
          slave_valid_d = 1'b1;
          slave_out_d   = sat_mag(cnt_q);
          lead_d        = 1'b1;
          state_d       = IDLE;
          cnt_d         = '0;
        end else if (fb_e_q) begin
          slave_valid_d = 1'b1;
          slave_out_d   = MAG_MAX;
          lead_d        = 1'b1;
          cnt_d         = CNT_ONE;
        end else if (cnt_q == CNT_TIMEOUT) begin
          slave_valid_d = 1'b1;
          slave_out_d   = MAG_MAX;
          lead_d        = 1'b1;
          state_d       = IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_sync_q    <= '0;
      fb_sync_q     <= '0;
      ref_prev_q    <= 1'b0;
      fb_prev_q     <= 1'b0;
      ref_e_q       <= 1'b0;
      fb_e_q        <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      slave_out_q   <= '0;
      lead_q        <= 1'b0;
      slave_valid_q <= 1'b0;
    end else begin
      ref_sync_q    <= ref_sync_d;
      fb_sync_q     <= fb_sync_d;
      ref_prev_q    <= ref_prev_d;
      fb_prev_q     <= fb_prev_d;
      ref_e_q       <= ref_e_d;
      fb_e_q        <= fb_e_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slave_out_q   <= slave_out_d;
      lead_q        <= lead_d;
      slave_valid_q <= slave_valid_d;
    end
  end

  assign slave_out   = slave_out_q;
  assign lead        = lead_q;
  assign slave_valid = slave_valid_q;

endmodule

// File: tb/tb_pfd_tdc_counter.sv
// Bench for pfd_tdc_counter: scenario tasks drive ref/fb edges and push expected
// {lead, magnitude} results; a negedge monitor pops and compares on each valid pulse.
module tb_pfd_tdc_counter;

  localparam int MAG_WIDTH   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 1023;
  localparam int EDGE_LAT    = SYNC_STAGES + 2;
  localparam logic [MAG_WIDTH-1:0] MAG_MAX = '1;

  logic                 clk;
  logic                 rstn;
  logic                 ref_in;
  logic                 fb_in;
  logic [MAG_WIDTH-1:0] slave_out;
  logic                 lead;
  logic                 slave_valid;

  logic [MAG_WIDTH:0] exp_q[$];
  int checks;
  int errors;

  pfd_tdc_counter #(
    .MAG_WIDTH  (MAG_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ref_in     (ref_in),
    .fb_in      (fb_in),
    .slave_out  (slave_out),
    .lead       (lead),
    .slave_valid(slave_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn && slave_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got lead=%0b mag=%0d, required no pulse", lead, slave_out);
      end else begin
        logic [MAG_WIDTH:0] exp;
        exp = exp_q.pop_front();
        if ({lead, slave_out} !== exp) begin
          errors++;
          $display("FAIL result got lead=%0b mag=%0d, required lead=%0b mag=%0d",
                   lead, slave_out, exp[MAG_WIDTH], exp[MAG_WIDTH-1:0]);
        end
      end
    end
  end

  // Driver helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic l, input int mag);
    logic [MAG_WIDTH-1:0] m;
    m = (mag > MAG_MAX) ? MAG_MAX : mag[MAG_WIDTH-1:0];
    exp_q.push_back({l, m});
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (slave_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout got no pulse in %0d cycles, required a pulse", budget);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending results, required 0", exp_q.size());
    end
  endtask

  task automatic release_inputs();
    ref_in = 1'b0;
    fb_in  = 1'b0;
    tick(6);
  endtask

  // Scenarios
  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ref_in = 1'($urandom_range(0, 1));
      fb_in  = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({slave_valid, lead, slave_out} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got v=%0b l=%0b mag=%0d, required all 0", slave_valid, lead, slave_out);
      end
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    tick(2);
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (slave_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet got valid=%0b, required 0", slave_valid);
      end
    end
  endtask

  task automatic test_ref_lead();
    int lat;
    ref_in = 1'b1;
    tick(37);
    fb_in = 1'b1;
    push_exp(1'b0, 37);
    wait_valid(20, lat);
    checks++;
    if (lat !== EDGE_LAT) begin
      errors++;
      $display("FAIL ref_lead_latency got %0d, required %0d", lat, EDGE_LAT);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (slave_valid !== 1'b0 || slave_out !== 8'd37 || lead !== 1'b0) begin
        errors++;
        $display("FAIL hold got v=%0b l=%0b mag=%0d, required v=0 l=0 mag=37", slave_valid, lead, slave_out);
      end
    end
    release_inputs();
  endtask

  task automatic test_fb_lead_and_coincident();
    int lat;
    fb_in = 1'b1;
    tick(12);
    ref_in = 1'b1;
    push_exp(1'b1, 12);
    wait_valid(20, lat);
    release_inputs();
    ref_in = 1'b1;
    fb_in  = 1'b1;
    push_exp(1'b1, 0);
    wait_valid(20, lat);
    checks++;
    if (lat !== EDGE_LAT) begin
      errors++;
      $display("FAIL coincident_latency got %0d, required %0d", lat, EDGE_LAT);
    end
    tick(2);
    checks++;
    if (lead !== 1'b1 || slave_out !== '0) begin
      errors++;
      $display("FAIL coincident_hold got l=%0b mag=%0d, required l=1 mag=0", lead, slave_out);
    end
    release_inputs();
  endtask

  task automatic test_saturate_timeout();
    int lat;
    ref_in = 1'b1;
    tick(400);
    fb_in = 1'b1;
    push_exp(1'b0, 400);
    wait_valid(20, lat);
    release_inputs();
    ref_in = 1'b1;
    push_exp(1'b0, 255);
    wait_valid(TIMEOUT + 100, lat);
    checks++;
    if (lat !== TIMEOUT + EDGE_LAT) begin
      errors++;
      $display("FAIL timeout_latency got %0d, required %0d", lat, TIMEOUT + EDGE_LAT);
    end
    ref_in = 1'b0;
    tick(6);
    // Back in IDLE: a fresh fb-first pair must measure normally
    fb_in = 1'b1;
    tick(7);
    ref_in = 1'b1;
    push_exp(1'b1, 7);
    drain(20);
    release_inputs();
  endtask

  task automatic test_cycle_slip();
    ref_in = 1'b1;
    tick(50);
    ref_in = 1'b0;
    tick(50);
    ref_in = 1'b1;
    push_exp(1'b0, 255);
    push_exp(1'b0, 20);
    tick(20);
    fb_in = 1'b1;
    drain(20);
    release_inputs();
  endtask

  task automatic test_reset_mid();
    ref_in = 1'b1;
    tick(53);
    rstn   = 1'b0;
    ref_in = 1'b0;
    tick(3);
    checks++;
    if ({slave_valid, lead, slave_out} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got v=%0b l=%0b mag=%0d, required all 0", slave_valid, lead, slave_out);
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (slave_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet got valid=%0b, required 0", slave_valid);
      end
    end
    ref_in = 1'b1;
    tick(5);
    fb_in = 1'b1;
    push_exp(1'b0, 5);
    drain(20);
    release_inputs();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      int  d;
      logic fb_first;
      d        = $urandom_range(1, 300);
      fb_first = 1'($urandom_range(0, 1));
      if (fb_first) fb_in = 1'b1;
      else          ref_in = 1'b1;
      tick(d);
      if (fb_first) ref_in = 1'b1;
      else          fb_in = 1'b1;
      push_exp(fb_first, d);
      drain(20);
      release_inputs();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    test_reset();
    test_ref_lead();
    test_fb_lead_and_coincident();
    test_saturate_timeout();
    test_cycle_slip();
    test_reset_mid();
    test_back_to_back();
    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
